// File: rtl/prbs32_checker.sv
// Self-synchronising receive checker for the 32-bit Fibonacci PRBS (x32+x30+x17+x12+x3+x+1).
// Fills, verifies, then predicts the stream; counts mismatches and drops lock when errors get dense.
module prbs32_checker #(
    parameter int LOCK_CNT = 64,
    parameter int WIN      = 32,
    parameter int LOSS_THR = 8,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             din,
    input  logic             din_vld,
    input  logic             cnt_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       state
);

    localparam int WCW = $clog2(WIN);
    localparam int EW  = $clog2(LOSS_THR + 1);

    typedef enum logic [1:0] {
        ST_FILL   = 2'b00,
        ST_VERIFY = 2'b01,
        ST_LOCKED = 2'b10,
        ST_BAD    = 2'b11
    } state_t;

    function automatic logic pred_bit(input logic [31:0] s);
        return s[0] ^ s[2] ^ s[11] ^ s[16] ^ s[29] ^ s[31];
    endfunction

    state_t           state_r, state_s;
    logic [31:0]      shreg_r, shreg_s;
    logic [4:0]       fill_cnt_r, fill_cnt_s;
    logic [7:0]       good_cnt_r, good_cnt_s;
    logic [WCW-1:0]   win_cnt_r, win_cnt_s;
    logic [EW-1:0]    win_err_r, win_err_s;
    logic [ERR_W-1:0] err_cnt_r, err_cnt_s, err_inc_s;
    logic             err_pulse_r, locked_r;
    logic             pred_s, mis_s;
    logic [8:0]       good_inc_s;

    // Next-state and counter update for one valid bit; unused encoding falls back to FILL.
    always_comb begin
        state_s    = state_r;
        shreg_s    = shreg_r;
        fill_cnt_s = fill_cnt_r;
        good_cnt_s = good_cnt_r;
        win_cnt_s  = win_cnt_r;
        win_err_s  = win_err_r;
        mis_s      = 1'b0;
        pred_s     = pred_bit(shreg_r);
        good_inc_s = {1'b0, good_cnt_r} + 9'd1;
        case (state_r)
            ST_FILL: begin
                if (din_vld) begin
                    shreg_s = {shreg_r[30:0], din};
                    if (fill_cnt_r == 5'd31) begin
                        state_s    = ST_VERIFY;
                        fill_cnt_s = 5'd0;
                        good_cnt_s = 8'd0;
                    end else begin
                        fill_cnt_s = fill_cnt_r + 5'd1;
                    end
                end else begin
                    shreg_s = shreg_r;
                end
            end
            ST_VERIFY: begin
                if (din_vld) begin
                    shreg_s = {shreg_r[30:0], din};
                    // An all-zero register is a degenerate fixed point and must never lock.
                    if (shreg_s == 32'd0) begin
                        good_cnt_s = 8'd0;
                    end else if (din == pred_s) begin
                        if (good_inc_s == 9'(LOCK_CNT)) begin
                            state_s    = ST_LOCKED;
                            good_cnt_s = 8'd0;
                            win_cnt_s  = {WCW{1'b0}};
                            win_err_s  = {EW{1'b0}};
                        end else begin
                            good_cnt_s = good_inc_s[7:0];
                        end
                    end else begin
                        good_cnt_s = 8'd0;
                    end
                end else begin
                    shreg_s = shreg_r;
                end
            end
            ST_LOCKED: begin
                if (din_vld) begin
                    // Feed back the prediction so one channel error is counted only once.
                    shreg_s   = {shreg_r[30:0], pred_s};
                    mis_s     = din ^ pred_s;
                    win_err_s = win_err_r + EW'(mis_s);
                    if (win_err_s == EW'(LOSS_THR)) begin
                        state_s    = ST_FILL;
                        fill_cnt_s = 5'd0;
                        good_cnt_s = 8'd0;
                        win_cnt_s  = {WCW{1'b0}};
                        win_err_s  = {EW{1'b0}};
                    end else if (win_cnt_r == WCW'(WIN - 1)) begin
                        win_cnt_s = {WCW{1'b0}};
                        win_err_s = {EW{1'b0}};
                    end else begin
                        win_cnt_s = win_cnt_r + WCW'(1);
                    end
                end else begin
                    shreg_s = shreg_r;
                end
            end
            default: begin
                state_s    = ST_FILL;
                fill_cnt_s = 5'd0;
                good_cnt_s = 8'd0;
                win_cnt_s  = {WCW{1'b0}};
                win_err_s  = {EW{1'b0}};
            end
        endcase
    end

    // Saturating error counter; a clear coinciding with a mismatch still records that mismatch.
    always_comb begin
        if (err_cnt_r == {ERR_W{1'b1}}) begin
            err_inc_s = err_cnt_r;
        end else begin
            err_inc_s = err_cnt_r + ERR_W'(1);
        end
        if (cnt_clr) begin
            err_cnt_s = ERR_W'(mis_s);
        end else if (mis_s) begin
            err_cnt_s = err_inc_s;
        end else begin
            err_cnt_s = err_cnt_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_r     <= ST_FILL;
            shreg_r     <= 32'd0;
            fill_cnt_r  <= 5'd0;
            good_cnt_r  <= 8'd0;
            win_cnt_r   <= {WCW{1'b0}};
            win_err_r   <= {EW{1'b0}};
            err_cnt_r   <= {ERR_W{1'b0}};
            err_pulse_r <= 1'b0;
            locked_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            shreg_r     <= shreg_s;
            fill_cnt_r  <= fill_cnt_s;
            good_cnt_r  <= good_cnt_s;
            win_cnt_r   <= win_cnt_s;
            win_err_r   <= win_err_s;
            err_cnt_r   <= err_cnt_s;
            err_pulse_r <= mis_s;
            locked_r    <= (state_s == ST_LOCKED);
        end
    end

    assign locked    = locked_r;
    assign err_pulse = err_pulse_r;
    assign err_cnt   = err_cnt_r;
    assign state     = state_r;

endmodule

// File: tb/tb_prbs32_checker.sv
// Self-checking bench for prbs32_checker: directed scenarios plus a random phase,
// all compared against a stream-level reference model of the checker.
module tb_prbs32_checker;

    localparam int LOCK_CNT = 64;
    localparam int WIN      = 32;
    localparam int LOSS_THR = 8;

    logic        clk = 1'b0;
    logic        clear_n, din, din_vld, cnt_clr;
    logic        locked, err_pulse, locked4, err_pulse4;
    logic [15:0] err_cnt;
    logic [3:0]  err_cnt4;
    logic [1:0]  state, state4;

    int n_assert = 0;
    int n_fail   = 0;

    prbs32_checker #(.LOCK_CNT(LOCK_CNT), .WIN(WIN), .LOSS_THR(LOSS_THR), .ERR_W(16)) dut (
        .clk(clk), .clear_n(clear_n), .din(din), .din_vld(din_vld), .cnt_clr(cnt_clr),
        .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .state(state));

    prbs32_checker #(.LOCK_CNT(LOCK_CNT), .WIN(WIN), .LOSS_THR(LOSS_THR), .ERR_W(4)) dut4 (
        .clk(clk), .clear_n(clear_n), .din(din), .din_vld(din_vld), .cnt_clr(cnt_clr),
        .locked(locked4), .err_pulse(err_pulse4), .err_cnt(err_cnt4), .state(state4));

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "timeout");
    end

    // Generator: whole stream kept as a growing array, b[n] from the polynomial recurrence.
    bit stream[$];

    // Reference model: 0=FILL 1=VERIFY 2=LOCKED; hist holds the last 32 bits the checker kept.
    int m_mode, m_fill, m_good, m_wpos, m_werr, m_err16, m_err4;
    bit m_pulse;
    bit m_hist[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic gen_bit(output bit b);
        int n = stream.size();
        b = stream[n-1] ^ stream[n-3] ^ stream[n-12] ^ stream[n-17] ^ stream[n-30] ^ stream[n-32];
        stream.push_back(b);
    endtask

    function automatic bit age(input int k);
        return m_hist[m_hist.size() - 1 - k];
    endfunction

    function automatic int sat_add(input int v, input int inc, input int maxv);
        return (v + inc > maxv) ? maxv : v + inc;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_fill = 0; m_good = 0; m_wpos = 0; m_werr = 0;
        m_err16 = 0; m_err4 = 0; m_pulse = 1'b0;
        m_hist.delete();
        for (int i = 0; i < 32; i++) m_hist.push_back(1'b0);
    endtask

    task automatic push_hist(input bit b);
        m_hist.push_back(b);
        void'(m_hist.pop_front());
    endtask

    task automatic model_step(input bit d, input bit v, input bit c);
        bit p, e, nz;
        e = 1'b0;
        if (v) begin
            p = age(0) ^ age(2) ^ age(11) ^ age(16) ^ age(29) ^ age(31);
            if (m_mode == 0) begin
                push_hist(d);
                m_fill++;
                if (m_fill == 32) begin m_mode = 1; m_fill = 0; m_good = 0; end
            end else if (m_mode == 1) begin
                push_hist(d);
                nz = 1'b0;
                foreach (m_hist[i]) nz |= m_hist[i];
                if (!nz) m_good = 0;
                else if (d == p) begin
                    m_good++;
                    if (m_good == LOCK_CNT) begin m_mode = 2; m_good = 0; m_wpos = 0; m_werr = 0; end
                end else m_good = 0;
            end else begin
                push_hist(p);
                e = (d != p);
                m_werr += int'(e);
                m_wpos++;
                if (m_werr == LOSS_THR) begin
                    m_mode = 0; m_fill = 0; m_good = 0; m_wpos = 0; m_werr = 0;
                end else if (m_wpos == WIN) begin
                    m_wpos = 0; m_werr = 0;
                end
            end
        end
        m_pulse = e;
        m_err16 = c ? int'(e) : sat_add(m_err16, int'(e), 65535);
        m_err4  = c ? int'(e) : sat_add(m_err4, int'(e), 15);
    endtask

    task automatic check_outputs();
        chk("state", 32'(state), 32'(m_mode));
        chk("locked", 32'(locked), 32'(m_mode == 2));
        chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
        chk("err_cnt", 32'(err_cnt), 32'(m_err16));
        chk("state4", 32'(state4), 32'(m_mode));
        chk("err_cnt4", 32'(err_cnt4), 32'(m_err4));
    endtask

    task automatic cycle(input bit d, input bit v, input bit c);
        din = d; din_vld = v; cnt_clr = c;
        @(posedge clk);
        #1;
        model_step(d, v, c);
        check_outputs();
    endtask

    task automatic send(input bit flip);
        bit b;
        gen_bit(b);
        cycle(b ^ flip, 1'b1, 1'b0);
    endtask

    task automatic send_clr();
        bit b;
        gen_bit(b);
        cycle(b, 1'b1, 1'b1);
    endtask

    task automatic wait_wpos(input int pos);
        for (int i = 0; i < 2 * WIN && m_wpos != pos; i++) send(1'b0);
        n_assert++;
        assert (m_wpos == pos && locked === 1'b1) else begin
            n_fail++;
            $error("FAIL wait_wpos: window position %0d locked %b, required %0d and 1", m_wpos, locked, pos);
        end
    endtask

    task automatic relock_96(input string tag);
        for (int i = 1; i <= 96; i++) begin
            send(1'b0);
            if (i == 95) chk({tag, "_unlocked_95"}, 32'(locked), 32'd0);
        end
        chk({tag, "_locked_96"}, 32'(locked), 32'd1);
    endtask

    initial begin
        bit b;
        for (int i = 0; i < 32; i++) stream.push_back(1'b1);
        model_reset();
        clear_n = 1'b0; din = 1'b0; din_vld = 1'b0; cnt_clr = 1'b0;
        #12;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_err_pulse", 32'(err_pulse), 32'd0);
        chk("reset_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk);
        #1 clear_n = 1'b1;

        // Clean acquisition and long run.
        for (int i = 1; i <= 10000; i++) begin
            send(1'b0);
            if (i == 31) chk("fill_at_31", 32'(state), 32'd0);
            if (i == 32) chk("verify_at_32", 32'(state), 32'd1);
            if (i == 95) chk("unlocked_at_95", 32'(locked), 32'd0);
            if (i == 96) chk("locked_at_96", 32'(locked), 32'd1);
        end
        chk("clean_err_cnt", 32'(err_cnt), 32'd0);

        // Single flipped bit at index 500.
        for (int i = 1; i <= 1000; i++) begin
            send(i == 500);
            if (i == 500) chk("single_pulse", 32'(err_pulse), 32'd1);
            if (i == 501) chk("single_pulse_gone", 32'(err_pulse), 32'd0);
        end
        chk("single_err_cnt", 32'(err_cnt), 32'd1);
        chk("single_locked", 32'(locked), 32'd1);

        // Clear alone, then clear together with an error.
        send_clr();
        chk("clr_alone", 32'(err_cnt), 32'd0);
        gen_bit(b);
        cycle(~b, 1'b1, 1'b1);
        chk("clr_with_err", 32'(err_cnt), 32'd1);

        // Eight errors spread inside one window force loss, then relock.
        send_clr();
        wait_wpos(0);
        for (int k = 0; k < 8; k++) begin
            send(1'b1);
            if (k < 7) begin send(1'b0); send(1'b0); end
        end
        chk("loss8_locked", 32'(locked), 32'd0);
        chk("loss8_state", 32'(state), 32'd0);
        chk("loss8_err_cnt", 32'(err_cnt), 32'd8);
        relock_96("loss8");

        // Seven errors either side of a window wrap keep lock.
        send_clr();
        wait_wpos(WIN - 7);
        for (int k = 0; k < 14; k++) send(1'b1);
        chk("split14_locked", 32'(locked), 32'd1);
        chk("split14_err_cnt", 32'(err_cnt), 32'd14);

        // Threshold reached on the last bit of a window: loss beats wrap.
        send_clr();
        wait_wpos(WIN - 8);
        for (int k = 0; k < 8; k++) send(1'b1);
        chk("lastbit_locked", 32'(locked), 32'd0);
        chk("lastbit_state", 32'(state), 32'd0);
        relock_96("lastbit");

        // Twenty isolated errors saturate the 4-bit counter.
        send_clr();
        for (int k = 0; k < 20; k++) begin
            wait_wpos(5);
            send(1'b1);
        end
        chk("sat_err_cnt4", 32'(err_cnt4), 32'd15);
        chk("sat_err_cnt16", 32'(err_cnt), 32'd20);

        // Asynchronous reset while locked.
        clear_n = 1'b0;
        #2;
        chk("async_locked", 32'(locked), 32'd0);
        chk("async_err_cnt", 32'(err_cnt), 32'd0);
        chk("async_state", 32'(state), 32'd0);
        model_reset();
        @(posedge clk);
        #1 clear_n = 1'b1;

        // All-zero input never locks; the real stream then locks within 96 bits.
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 1'b0);
        chk("zero_state", 32'(state), 32'd1);
        chk("zero_locked", 32'(locked), 32'd0);
        for (int i = 0; i < 96; i++) send(1'b0);
        chk("zero_then_locked", 32'(locked), 32'd1);

        // din_vld alternating; random din on idle cycles.
        clear_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1 clear_n = 1'b1;
        for (int i = 1; i <= 96; i++) begin
            if (i == 96) chk("toggle_unlocked_95", 32'(locked), 32'd0);
            send(1'b0);
            cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        chk("toggle_locked_96", 32'(locked), 32'd1);

        // Random valid pattern, sparse errors and clears.
        for (int i = 0; i < 3000; i++) begin
            bit v, f, c;
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 39) == 0);
            c = ($urandom_range(0, 99) == 0);
            if (v) begin
                gen_bit(b);
                cycle(b ^ f, 1'b1, c);
            end else begin
                cycle(1'($urandom_range(0, 1)), 1'b0, c);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
